sram_port_arbiter: RTL and testbench

Shares one 512x32 single-port synchronous SRAM (RAM_EN/RAM_A/RAM_WE/RAM_Di/RAM_Do) between several requester engines: object loader, neighbor-list builder, and subdivision stage. It uses round-robin arbitration with an optional bounded lock, so one engine can run an uninterrupted read-modify-write sequence. The arbiter issues at most one access per cycle and returns read data one cycle after the grant.

---
 rtl/sram_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one 512x32 single-port synchronous SRAM
// between NUM_REQ requester engines. A requester may hold the port for a
// bounded run of consecutive accesses (lock tenure, at most MAX_LOCK grants)
// to perform uninterrupted read-modify-write sequences.
module sram_port_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int MAX_LOCK = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      lock,
    input  logic [4*NUM_REQ-1:0]    we,
    input  logic [9*NUM_REQ-1:0]    addr,
    input  logic [32*NUM_REQ-1:0]   wdata,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      rvalid,
    output logic [31:0]             rdata,
    output logic                    RAM_EN,
    output logic [8:0]              RAM_A,
    output logic [3:0]              RAM_WE,
    output logic [31:0]             RAM_Di,
    input  logic [31:0]             RAM_Do
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // FREE: round-robin among all requesters; LOCKED: only the owner is eligible
    typedef enum logic {
        FREE   = 1'b0,
        LOCKED = 1'b1
    } mode_e;

    mode_e              mode_q, mode_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [7:0]         lock_cnt_q, lock_cnt_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

    logic [3:0]         we_s    [NUM_REQ];
    logic [8:0]         addr_s  [NUM_REQ];
    logic [31:0]        wdata_s [NUM_REQ];

    logic               win_valid;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   nxt_ptr;
    logic [8:0]         lock_inc;
    logic               at_max;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign we_s[g]    = we[4*g +: 4];
        assign addr_s[g]  = addr[9*g +: 9];
        assign wdata_s[g] = wdata[32*g +: 32];
    end

    // Winner selection: owner only while locked, otherwise first request at or after rr_ptr
    always_comb begin
        int               c;
        logic [PTR_W-1:0] cand;
        win_valid = 1'b0;
        win_idx   = '0;
        c         = 0;
        cand      = '0;
        if (mode_q == LOCKED) begin
            win_valid = req[owner_q];
            win_idx   = owner_q;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                c = int'(rr_ptr_q) + k;
                if (c >= NUM_REQ) c = c - NUM_REQ;
                cand = PTR_W'(c);
                if (!win_valid && req[cand]) begin
                    win_valid = 1'b1;
                    win_idx   = cand;
                end
            end
        end
        // No access may reach the SRAM while reset is held
        if (!rst_n) win_valid = 1'b0;
    end

    // Grant vector and SRAM port drive, all zero when nobody wins
    always_comb begin
        gnt    = '0;
        RAM_EN = 1'b0;
        RAM_A  = '0;
        RAM_WE = '0;
        RAM_Di = '0;
        if (win_valid) begin
            gnt[win_idx] = 1'b1;
            RAM_EN       = 1'b1;
            RAM_A        = addr_s[win_idx];
            RAM_WE       = we_s[win_idx];
            RAM_Di       = wdata_s[win_idx];
        end
    end

    assign nxt_ptr  = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign lock_inc = {1'b0, lock_cnt_q} + 9'd1;
    assign at_max   = (lock_inc == 9'(MAX_LOCK));

    // Next-state logic for mode, priority pointer, tenure counter and read return
    always_comb begin
        mode_d     = mode_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        rvalid_d   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rvalid_d[i] = gnt[i] & ~(|we_s[i]);
        end
        case (mode_q)
            FREE: begin
                if (win_valid) begin
                    rr_ptr_d = nxt_ptr;
                    if (lock[win_idx]) begin
                        if (at_max) begin
                            lock_cnt_d = '0;
                        end else begin
                            mode_d     = LOCKED;
                            owner_d    = win_idx;
                            lock_cnt_d = lock_inc[7:0];
                        end
                    end
                end
            end
            LOCKED: begin
                if (req[owner_q] && lock[owner_q] && !at_max) begin
                    lock_cnt_d = lock_inc[7:0];
                end else begin
                    // Voluntary exit or forced release: owner goes to the back of the ring
                    mode_d     = FREE;
                    lock_cnt_d = '0;
                    rr_ptr_d   = nxt_ptr;
                end
            end
            default: mode_d = FREE;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= FREE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            rvalid_q   <= '0;
        end else begin
            mode_q     <= mode_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = RAM_Do;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: SRAM model, behavioural
// arbiter/memory reference model, directed scenarios and random traffic.
module tb_sram_port_arbiter;

    localparam int N  = 3;
    localparam int ML = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_a  [N];
    logic             lock_a [N];
    logic [3:0]       we_a   [N];
    logic [8:0]       addr_a [N];
    logic [31:0]      wd_a   [N];
    logic [N-1:0]     req, lock;
    logic [4*N-1:0]   we;
    logic [9*N-1:0]   addr;
    logic [32*N-1:0]  wdata;
    logic [N-1:0]     gnt, rvalid;
    logic [31:0]      rdata;
    logic             RAM_EN;
    logic [8:0]       RAM_A;
    logic [3:0]       RAM_WE;
    logic [31:0]      RAM_Di;
    logic [31:0]      RAM_Do;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req[g]           = req_a[g];
        assign lock[g]          = lock_a[g];
        assign we[4*g +: 4]     = we_a[g];
        assign addr[9*g +: 9]   = addr_a[g];
        assign wdata[32*g +: 32] = wd_a[g];
    end

    sram_port_arbiter #(.NUM_REQ(N), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .RAM_EN(RAM_EN), .RAM_A(RAM_A), .RAM_WE(RAM_WE),
        .RAM_Di(RAM_Di), .RAM_Do(RAM_Do)
    );

    // 512x32 single-port synchronous SRAM with byte writes
    logic [31:0] mem [512];
    always @(posedge clk) begin
        if (RAM_EN) begin
            RAM_Do <= mem[RAM_A];
            for (int b = 0; b < 4; b++)
                if (RAM_WE[b]) mem[RAM_A][8*b +: 8] <= RAM_Di[8*b +: 8];
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: priority position, tenure owner and length, golden memory
    int          m_ptr = 0, m_owner = 0, m_cnt = 0;
    bit          m_locked = 1'b0;
    logic [31:0] gold [512];
    logic [N-1:0] exp_rv;
    logic [31:0] exp_rd;
    int          last_w = -1;
    logic [31:0] s_gnt, s_en, s_we, s_rv, s_rd;

    function automatic logic [1:0] ix(input int i);
        return 2'(i);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs already applied after a falling edge
    task automatic tick();
        int          w;
        logic [1:0]  wi;
        logic [N-1:0] eg;
        logic [31:0] ea, ewe, edi;
        #1;
        w = -1;
        if (rst_n) begin
            if (m_locked) begin
                if (req_a[ix(m_owner)]) w = m_owner;
            end else begin
                for (int k = 0; k < N; k++)
                    if (w < 0 && req_a[ix((m_ptr + k) % N)]) w = (m_ptr + k) % N;
            end
        end
        wi  = ix((w < 0) ? 0 : w);
        eg  = (w >= 0) ? (N'(1) << w) : '0;
        ea  = (w >= 0) ? 32'(addr_a[wi]) : 32'h0;
        ewe = (w >= 0) ? 32'(we_a[wi]) : 32'h0;
        edi = (w >= 0) ? wd_a[wi] : 32'h0;
        s_gnt = 32'(gnt);
        s_en  = 32'(RAM_EN);
        s_we  = 32'(RAM_WE);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("ram_en", 32'(RAM_EN), (w >= 0) ? 32'h1 : 32'h0);
        chk("ram_a", 32'(RAM_A), ea);
        chk("ram_we", 32'(RAM_WE), ewe);
        chk("ram_di", RAM_Di, edi);
        exp_rv = '0;
        exp_rd = '0;
        if (!rst_n) begin
            m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 1'b0;
        end else if (w >= 0) begin
            if (we_a[wi] == 4'h0) begin
                exp_rv = N'(1) << w;
                exp_rd = gold[addr_a[wi]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (we_a[wi][b]) gold[addr_a[wi]][8*b +: 8] = wd_a[wi][8*b +: 8];
            end
            // Tenure grows while lock is held and the run stays below MAX_LOCK grants
            if (lock_a[wi] && m_cnt + 1 < ML) begin
                m_locked = 1'b1; m_owner = w; m_cnt = m_cnt + 1;
            end else begin
                m_locked = 1'b0; m_cnt = 0; m_ptr = (w + 1) % N;
            end
        end else if (m_locked) begin
            m_locked = 1'b0; m_cnt = 0; m_ptr = (m_owner + 1) % N;
        end
        last_w = w;
        @(posedge clk);
        #1;
        s_rv = 32'(rvalid);
        s_rd = rdata;
        chk("rvalid", 32'(rvalid), 32'(exp_rv));
        if (exp_rv != '0) chk("rdata", rdata, exp_rd);
        @(negedge clk);
    endtask

    task automatic set(input int i, input logic r, input logic l, input logic [3:0] w,
                       input logic [8:0] a, input logic [31:0] d);
        req_a[ix(i)]  = r;
        lock_a[ix(i)] = l;
        we_a[ix(i)]   = w;
        addr_a[ix(i)] = a;
        wd_a[ix(i)]   = d;
    endtask

    task automatic idle();
        for (int i = 0; i < N; i++) set(i, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
    endtask

    function automatic logic [31:0] pre_val(input int i);
        return 32'h5555_0005 + 32'(i) * 32'h1111_0001;
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        @(negedge clk);

        // Reset holds everything off even with writes requested
        for (int i = 0; i < N; i++) set(i, 1'b1, 1'b0, 4'hF, 9'h0, 32'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_gnt", s_gnt, 32'h0);
            chk("rst_en", s_en, 32'h0);
            chk("rst_we", s_we, 32'h0);
            chk("rst_rv", s_rv, 32'h0);
        end
        rst_n = 1'b1;

        // Simultaneous writes to 5,6,7: first grant after reset goes to req0
        for (int i = 0; i < N; i++) set(i, 1'b1, 1'b0, 4'hF, 9'(5 + i), pre_val(i));
        tick(); chk("first_gnt", s_gnt, 32'h1); req_a[0] = 1'b0;
        tick(); chk("wr_gnt1", s_gnt, 32'h2);   req_a[1] = 1'b0;
        tick(); chk("wr_gnt2", s_gnt, 32'h4);   req_a[2] = 1'b0;

        // Round robin reads, held for six cycles
        for (int i = 0; i < N; i++) set(i, 1'b1, 1'b0, 4'h0, 9'(5 + i), 32'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_gnt", s_gnt, 32'h1 << (k % 3));
            chk("rr_rv", s_rv, 32'h1 << (k % 3));
            chk("rr_rdata", s_rd, pre_val(k % 3));
        end
        idle();

        // Preload the small address window used by random traffic
        for (int a = 0; a < 16; a++) begin
            if (a < 5 || a > 7) begin
                set(0, 1'b1, 1'b0, 4'hF, 9'(a), 32'hC0DE_0000 | 32'(a));
                tick();
            end
        end
        idle();

        // Read after write
        set(1, 1'b1, 1'b0, 4'hF, 9'h1A0, 32'hDEAD_BEEF);
        tick(); chk("raw_wr_gnt", s_gnt, 32'h2); chk("raw_wr_rv", s_rv, 32'h0);
        set(1, 1'b1, 1'b0, 4'h0, 9'h1A0, 32'h0);
        tick(); chk("raw_rv", s_rv, 32'h2); chk("raw_rdata", s_rd, 32'hDEAD_BEEF);

        // Byte enables
        set(1, 1'b1, 1'b0, 4'hF, 9'h1A1, 32'h1122_3344); tick();
        set(1, 1'b1, 1'b0, 4'b0010, 9'h1A1, 32'hAABB_CCDD); tick();
        set(1, 1'b1, 1'b0, 4'h0, 9'h1A1, 32'h0);
        tick(); chk("be_rdata", s_rd, 32'h1122_CC44);
        idle();

        // Move priority to req0, then a full tenure forced to release after 16 grants
        set(2, 1'b1, 1'b0, 4'h0, 9'h2, 32'h0); tick(); idle();
        set(0, 1'b1, 1'b1, 4'h0, 9'h0, 32'h0);
        set(1, 1'b1, 1'b0, 4'h0, 9'h1, 32'h0);
        set(2, 1'b1, 1'b0, 4'h0, 9'h2, 32'h0);
        for (int k = 0; k < 17; k++) begin
            tick();
            chk("lock_gnt", s_gnt, (k < 16) ? 32'h1 : 32'h2);
        end
        idle();

        // Voluntary exit: lock dropped on the fifth grant
        set(2, 1'b1, 1'b0, 4'h0, 9'h2, 32'h0); tick(); idle();
        set(0, 1'b1, 1'b1, 4'h0, 9'h0, 32'h0);
        set(1, 1'b1, 1'b0, 4'h0, 9'h1, 32'h0);
        set(2, 1'b1, 1'b0, 4'h0, 9'h2, 32'h0);
        for (int k = 0; k < 6; k++) begin
            if (k == 4) lock_a[0] = 1'b0;
            tick();
            chk("unlock_gnt", s_gnt, (k < 5) ? 32'h1 : 32'h2);
        end
        idle();

        // Reset in the middle of a req2 read tenure
        set(2, 1'b1, 1'b1, 4'h0, 9'h3, 32'h0);
        tick(); chk("ml_gnt", s_gnt, 32'h4); chk("ml_rv", s_rv, 32'h4);
        tick(); chk("ml_gnt2", s_gnt, 32'h4);
        rst_n = 1'b0;
        tick(); chk("ml_rst_gnt", s_gnt, 32'h0); chk("ml_rst_rv", s_rv, 32'h0);
        rst_n = 1'b1;
        set(0, 1'b1, 1'b0, 4'h0, 9'h4, 32'h0);
        set(1, 1'b1, 1'b0, 4'h0, 9'h5, 32'h0);
        tick(); chk("ml_after_gnt", s_gnt, 32'h1);
        idle();
        tick();

        // Random traffic respecting the hold-until-grant protocol
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (req_a[ix(i)] && last_w != i) begin
                    if ($urandom_range(0, 15) == 0) req_a[ix(i)] = 1'b0;
                end else begin
                    req_a[ix(i)]  = 1'($urandom_range(0, 1));
                    lock_a[ix(i)] = ($urandom_range(0, 9) < 4);
                    we_a[ix(i)]   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                    addr_a[ix(i)] = 9'($urandom_range(0, 15));
                    wd_a[ix(i)]   = $urandom;
                end
            end
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
